// File: rtl/id_ex_forward_stage_pkg.sv
// Shared constants for the ID/EX register and its forwarding control.
package id_ex_forward_stage_pkg;

    localparam logic [1:0] FWD_IDEX  = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_AW = 5;

    // Register 0 reads as zero and is never a forwarding or hazard source.
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/id_ex_forward_stage_fwd_select.sv
// Forwarding-select decode for one EX source operand; EX/MEM beats MEM/WB.
module fwd_select
    import id_ex_forward_stage_pkg::*;
#(
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic [REG_AW-1:0] src,
    input  logic [REG_AW-1:0] ex_mem_rd,
    input  logic              ex_mem_we,
    input  logic [REG_AW-1:0] mem_wb_rd,
    input  logic              mem_wb_we,
    output logic [1:0]        sel
);

    localparam logic [REG_AW-1:0] ZERO = REG_AW'(REG_ZERO);

    logic hit_exmem;
    logic hit_memwb;

    assign hit_exmem = ex_mem_we & (ex_mem_rd != ZERO) & (ex_mem_rd == src);
    assign hit_memwb = mem_wb_we & (mem_wb_rd != ZERO) & (mem_wb_rd == src);

    always_comb begin
        sel = FWD_IDEX;
        if (hit_exmem) begin
            sel = FWD_EXMEM;
        end else if (hit_memwb) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/id_ex_forward_stage.sv
// ID/EX pipeline register with load-use stall, flush bubbles, WB write-through and forwarding selects.
module id_ex_forward_stage
    import id_ex_forward_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    input  logic [REG_AW-1:0] ex_mem_rd,
    input  logic              ex_mem_reg_write,
    input  logic [REG_AW-1:0] mem_wb_rd,
    input  logic              mem_wb_reg_write,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall,
    output logic              ex_valid,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [REG_AW-1:0] ZERO = REG_AW'(REG_ZERO);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    logic hz;
    logic wb_hit_rs;
    logic wb_hit_rt;

    assign hz = ex_valid & ex_mem_read & (ex_rd != ZERO) & id_valid
              & ((ex_rd == id_rs) | (ex_rd == id_rt));
    assign stall = hz & ~flush;

    // The register file is written at the end of WB, so a same-cycle read in ID is stale.
    assign wb_hit_rs = mem_wb_reg_write & (mem_wb_rd != ZERO) & (mem_wb_rd == id_rs);
    assign wb_hit_rt = mem_wb_reg_write & (mem_wb_rd != ZERO) & (mem_wb_rd == id_rt);

    // ID -> EX stage boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_rs        <= '0;
            ex_rt        <= '0;
            ex_rd        <= '0;
            ex_rs_data   <= '0;
            ex_rt_data   <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            stall_cnt    <= '0;
        end else begin
            if (flush || stall) begin
                ex_valid     <= 1'b0;
                ex_rs        <= '0;
                ex_rt        <= '0;
                ex_rd        <= '0;
                ex_rs_data   <= '0;
                ex_rt_data   <= '0;
                ex_reg_write <= 1'b0;
                ex_mem_read  <= 1'b0;
            end else begin
                ex_valid     <= id_valid;
                ex_rs        <= id_rs;
                ex_rt        <= id_rt;
                ex_rd        <= id_rd;
                ex_rs_data   <= wb_hit_rs ? wb_data : id_rs_data;
                ex_rt_data   <= wb_hit_rt ? wb_data : id_rt_data;
                ex_reg_write <= id_reg_write & id_valid;
                ex_mem_read  <= id_mem_read & id_valid;
            end
            if (stall) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
        end
    end

    fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
        .src       (ex_rs),
        .ex_mem_rd (ex_mem_rd),
        .ex_mem_we (ex_mem_reg_write),
        .mem_wb_rd (mem_wb_rd),
        .mem_wb_we (mem_wb_reg_write),
        .sel       (fwd_a)
    );

    fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
        .src       (ex_rt),
        .ex_mem_rd (ex_mem_rd),
        .ex_mem_we (ex_mem_reg_write),
        .mem_wb_rd (mem_wb_rd),
        .mem_wb_we (mem_wb_reg_write),
        .sel       (fwd_b)
    );

endmodule

// File: tb/tb_id_ex_forward_stage.sv
// Directed bench for id_ex_forward_stage with a 4-bit stall counter to reach saturation quickly.
module tb_id_ex_forward_stage;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              id_valid = 1'b0;
    logic [REG_AW-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic [DATA_W-1:0] id_rs_data = '0, id_rt_data = '0;
    logic              id_reg_write = 1'b0, id_mem_read = 1'b0, flush = 1'b0;
    logic [REG_AW-1:0] ex_mem_rd = '0, mem_wb_rd = '0;
    logic              ex_mem_reg_write = 1'b0, mem_wb_reg_write = 1'b0;
    logic [DATA_W-1:0] wb_data = '0;
    logic              stall, ex_valid, ex_reg_write, ex_mem_read;
    logic [REG_AW-1:0] ex_rs, ex_rt, ex_rd;
    logic [DATA_W-1:0] ex_rs_data, ex_rt_data;
    logic [1:0]        fwd_a, fwd_b;
    logic [CNT_W-1:0]  stall_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    id_ex_forward_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .flush(flush), .ex_mem_rd(ex_mem_rd),
        .ex_mem_reg_write(ex_mem_reg_write), .mem_wb_rd(mem_wb_rd),
        .mem_wb_reg_write(mem_wb_reg_write), .wb_data(wb_data), .stall(stall),
        .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic v, input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rt,
                           input logic [REG_AW-1:0] rd, input logic [DATA_W-1:0] a,
                           input logic [DATA_W-1:0] b, input logic rw, input logic mr);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = a; id_rt_data = b; id_reg_write = rw; id_mem_read = mr;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_valid"}, 32'(ex_valid), 32'd0);
        chk({tag, "_rs"}, 32'(ex_rs), 32'd0);
        chk({tag, "_rt"}, 32'(ex_rt), 32'd0);
        chk({tag, "_rd"}, 32'(ex_rd), 32'd0);
        chk({tag, "_rs_data"}, ex_rs_data, 32'd0);
        chk({tag, "_rt_data"}, ex_rt_data, 32'd0);
        chk({tag, "_reg_write"}, 32'(ex_reg_write), 32'd0);
        chk({tag, "_mem_read"}, 32'(ex_mem_read), 32'd0);
    endtask

    initial begin
        // Reset with garbage on ID and live pipeline inputs
        present(1'b1, 5'd3, 5'd4, 5'd5, 32'hCAFE0001, 32'hCAFE0002, 1'b1, 1'b1);
        ex_mem_rd = 5'd3; ex_mem_reg_write = 1'b1; mem_wb_rd = 5'd4; mem_wb_reg_write = 1'b1;
        flush = 1'b1;
        tick();
        tick();
        chk_bubble("rst");
        chk("rst_fwd_a", 32'(fwd_a), 32'd0);
        chk("rst_fwd_b", 32'(fwd_b), 32'd0);
        chk("rst_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);

        // Plain capture
        rst = 1'b0; flush = 1'b0;
        ex_mem_reg_write = 1'b0; mem_wb_reg_write = 1'b0; ex_mem_rd = '0; mem_wb_rd = '0;
        present(1'b1, 5'd3, 5'd4, 5'd6, 32'h0000000A, 32'h0000000B, 1'b1, 1'b0);
        tick();
        chk("cap_valid", 32'(ex_valid), 32'd1);
        chk("cap_rs", 32'(ex_rs), 32'd3);
        chk("cap_rt", 32'(ex_rt), 32'd4);
        chk("cap_rd", 32'(ex_rd), 32'd6);
        chk("cap_rs_data", ex_rs_data, 32'h0000000A);
        chk("cap_rt_data", ex_rt_data, 32'h0000000B);
        chk("cap_reg_write", 32'(ex_reg_write), 32'd1);
        chk("cap_mem_read", 32'(ex_mem_read), 32'd0);

        // Forwarding selects, all within one cycle
        ex_mem_rd = 5'd3; ex_mem_reg_write = 1'b1; mem_wb_rd = 5'd3; mem_wb_reg_write = 1'b1;
        #1;
        chk("fwd_a_exmem_wins", 32'(fwd_a), 32'h2);
        chk("fwd_b_none", 32'(fwd_b), 32'h0);
        ex_mem_reg_write = 1'b0;
        #1;
        chk("fwd_a_memwb", 32'(fwd_a), 32'h1);
        ex_mem_rd = 5'd4; ex_mem_reg_write = 1'b1; mem_wb_rd = 5'd4;
        #1;
        chk("fwd_b_exmem", 32'(fwd_b), 32'h2);
        chk("fwd_a_cleared", 32'(fwd_a), 32'h0);
        ex_mem_rd = 5'd0; mem_wb_rd = 5'd0;
        #1;
        chk("fwd_a_r0", 32'(fwd_a), 32'h0);
        chk("fwd_b_r0", 32'(fwd_b), 32'h0);
        ex_mem_reg_write = 1'b0; mem_wb_reg_write = 1'b0;

        // Load-use hazard: load r5 then consumer reading r5 through rt
        present(1'b1, 5'd1, 5'd2, 5'd5, 32'h1, 32'h2, 1'b1, 1'b1);
        tick();
        chk("ld_mem_read", 32'(ex_mem_read), 32'd1);
        chk("ld_rd", 32'(ex_rd), 32'd5);
        present(1'b1, 5'd8, 5'd5, 5'd9, 32'h100, 32'h200, 1'b1, 1'b0);
        #1;
        chk("lu_stall", 32'(stall), 32'd1);
        tick();
        chk_bubble("lu_bubble");
        chk("lu_cnt", 32'(stall_cnt), 32'd1);
        chk("lu_stall_gone", 32'(stall), 32'd0);
        tick();
        chk("lu_cap_valid", 32'(ex_valid), 32'd1);
        chk("lu_cap_rt", 32'(ex_rt), 32'd5);
        chk("lu_cap_rd", 32'(ex_rd), 32'd9);
        chk("lu_cap_rt_data", ex_rt_data, 32'h200);
        chk("lu_cap_cnt", 32'(stall_cnt), 32'd1);

        // Flush overrides a simultaneous hazard
        present(1'b1, 5'd1, 5'd2, 5'd5, 32'h1, 32'h2, 1'b1, 1'b1);
        tick();
        present(1'b1, 5'd5, 5'd8, 5'd9, 32'h300, 32'h400, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        chk("fl_stall", 32'(stall), 32'd0);
        tick();
        flush = 1'b0;
        chk_bubble("fl_bubble");
        chk("fl_cnt", 32'(stall_cnt), 32'd1);

        // WB write-through on capture, per operand
        present(1'b1, 5'd7, 5'd4, 5'd9, 32'h11, 32'h22, 1'b1, 1'b0);
        mem_wb_rd = 5'd7; mem_wb_reg_write = 1'b1; wb_data = 32'hDEADBEEF;
        tick();
        chk("wb_rs_data", ex_rs_data, 32'hDEADBEEF);
        chk("wb_rt_data", ex_rt_data, 32'h22);
        present(1'b1, 5'd0, 5'd4, 5'd9, 32'h33, 32'h22, 1'b1, 1'b0);
        mem_wb_rd = 5'd0;
        tick();
        chk("wb_r0_rs_data", ex_rs_data, 32'h33);
        present(1'b1, 5'd7, 5'd7, 5'd9, 32'h44, 32'h55, 1'b1, 1'b0);
        mem_wb_rd = 5'd7; mem_wb_reg_write = 1'b0;
        tick();
        chk("wb_off_rs_data", ex_rs_data, 32'h44);
        chk("wb_off_rt_data", ex_rt_data, 32'h55);
        mem_wb_rd = 5'd0;

        // Twenty more load-use stalls drive the 4-bit counter into saturation
        for (int i = 0; i < 20; i++) begin
            present(1'b1, 5'd1, 5'd2, 5'd5, 32'h1, 32'h2, 1'b1, 1'b1);
            tick();
            present(1'b1, 5'd5, 5'd3, 5'd9, 32'h1, 32'h2, 1'b1, 1'b0);
            #1;
            chk($sformatf("sat_stall_%0d", i), 32'(stall), 32'd1);
            tick();
            chk($sformatf("sat_cnt_%0d", i), 32'(stall_cnt), (i + 2 > 15) ? 32'd15 : 32'(i + 2));
        end

        // Reset beats a pending hazard and flush
        present(1'b1, 5'd1, 5'd2, 5'd5, 32'h1, 32'h2, 1'b1, 1'b1);
        tick();
        present(1'b1, 5'd5, 5'd3, 5'd9, 32'h1, 32'h2, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_bubble("rst2");
        chk("rst2_cnt", 32'(stall_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_forward_stage.md
Name: id_ex_forward_stage

Overview:
- ID/EX pipeline register plus hazard/forwarding control; sits directly upstream of the EX-stage operand forwarding muxes.
- Captures decoded operands and control from ID and presents them to EX.
- Produces the two 2-bit forwarding selects consumed by those muxes: 00 = ID/EX value, 10 = EX/MEM result, 01 = MEM/WB result.
- Detects load-use hazards, inserts bubbles, and counts stall cycles.

Parameters:
DATA_W, 32, operand/data width
REG_AW, 5, register-address width (register 0 hard-wired zero)
CNT_W, 16, stall-counter width

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
id_valid  input  1  ID holds a real instruction
id_rs  input  REG_AW  source A register
id_rt  input  REG_AW  source B register
id_rd  input  REG_AW  destination register
id_rs_data  input  DATA_W  register-file read A
id_rt_data  input  DATA_W  register-file read B
id_reg_write  input  1  instruction writes rd
id_mem_read  input  1  instruction is a load
flush  input  1  branch/jump squash of ID instruction
ex_mem_rd  input  REG_AW  EX/MEM destination
ex_mem_reg_write  input  1  EX/MEM writes rd
mem_wb_rd  input  REG_AW  MEM/WB destination
mem_wb_reg_write  input  1  MEM/WB writes rd
wb_data  input  DATA_W  MEM/WB write-back value
stall  output  1  hold PC and IF/ID this cycle (combinational)
ex_valid  output  1  EX holds a real instruction
ex_rs, ex_rt, ex_rd  output  REG_AW each  registered addresses
ex_rs_data, ex_rt_data  output  DATA_W  registered operands (ID/EX mux input)
ex_reg_write, ex_mem_read  output  1  registered control
fwd_a, fwd_b  output  2  forwarding selects for operand A/B
stall_cnt  output  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (synchronous, rst=1 at posedge): every registered output = 0.
  - ex_valid=0; stall_cnt=0.
  - fwd_a and fwd_b therefore read 00.
  - rst has priority over flush and stall.
- Latency: one cycle, ID -> EX registers.
- Hazard term: hz = ex_valid & ex_mem_read & (ex_rd!=0) & id_valid & ((ex_rd==id_rs) | (ex_rd==id_rt)).
  - stall = hz & ~flush; combinational.
- Register update at each posedge (not rst), in priority order:
  - flush=1 -> bubble: ex_valid, ex_reg_write, ex_mem_read = 0; addresses and data = 0.
  - else stall=1 -> same bubble. ID contents are not captured; IF/ID holds them, so the instruction re-presents next cycle.
  - else -> capture all id_* fields. ex_valid=id_valid. ex_reg_write and ex_mem_read are ANDed with id_valid.
- WB write-through on capture, applied per operand independently:
  - if mem_wb_reg_write & mem_wb_rd!=0 & mem_wb_rd==id_rs, ex_rs_data <= wb_data instead of id_rs_data.
  - same rule for rt.
- Forwarding selects (combinational from registered ex_rs/ex_rt and live EX/MEM, MEM/WB inputs):
  - fwd_a=10 if ex_mem_reg_write & ex_mem_rd!=0 & ex_mem_rd==ex_rs.
  - else fwd_a=01 if mem_wb_reg_write & mem_wb_rd!=0 & mem_wb_rd==ex_rs.
  - else 00.
  - fwd_b uses the same rule on ex_rt.
  - EX/MEM wins when both stages match. 11 is never driven. Register 0 is never forwarded.
  - Bubbles carry rs=rt=0, so they always yield 00.
- stall_cnt increments by 1 on each posedge where stall=1, and saturates at all-ones.
- Simultaneous flush and hazard: flush wins; stall=0; no count.
- Hazard in consecutive cycles cannot persist: the bubble clears ex_mem_read, so a stall is exactly one cycle per load-use pair.

Decomposition:
- Shared package holds:
  - FWD_IDEX=2'b00, FWD_EXMEM=2'b10, FWD_MEMWB=2'b01;
  - REG_AW, DATA_W defaults;
  - REG_ZERO constant.
- One natural sub-module: fwd_select. It is combinational and instantiated twice (for rs and rt), taking src, ex_mem_rd/we, mem_wb_rd/we and returning the 2-bit select.

Test Plan:
- Reset: rst=1 for 2 cycles with garbage on id_* -> all outputs 0, fwd_a=fwd_b=00, stall_cnt=0.
- EX/MEM forward: capture rs=3; next cycle ex_mem_rd=3/we=1, mem_wb_rd=3/we=1 -> fwd_a=10. With ex_mem_we=0 -> fwd_a=01. With rd=0 on both -> 00.
- Load-use: load to r5 in EX (ex_mem_read=1); ID presents rt=5 -> stall=1 for exactly one cycle, bubble enters EX (ex_valid=0), stall_cnt=1. Next cycle stall=0 and the instruction is captured.
- Flush vs hazard: same setup as load-use plus flush=1 -> stall=0, bubble captured, stall_cnt unchanged.
- WB write-through: id_rs=7, id_rs_data=0x11, mem_wb_rd=7/we=1, wb_data=0xDEADBEEF -> ex_rs_data=0xDEADBEEF after the edge. With id_rs=0 -> ex_rs_data=id_rs_data.
- Counter saturation: CNT_W=4; 20 load-use stalls -> stall_cnt stops at 15.
